// File: rtl/zero_count_task.sv
// Registered zero-bit counter: one word per cycle, count presented one clock later.
// Optional all_zero/all_ones flags are enabled by defining ZERO_COUNT_FLAGS_EN.
module zero_count_task #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  out,
  output logic              out_valid,
  output logic              all_zero,
  output logic              all_ones
);

  // An X/Z bit fails the == 1'b0 test, so simulation does not count it as zero.
  function automatic logic [CNT_W-1:0] count_zeros(input logic [DATA_W-1:0] word);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (word[i] == 1'b0) n = n + CNT_W'(1);
    end
    return n;
  endfunction

  logic [CNT_W-1:0] count;

  always_comb begin
    count = count_zeros(data);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= count;
    end
  end

`ifdef ZERO_COUNT_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      all_zero <= 1'b0;
      all_ones <= 1'b0;
    end else if (in_valid) begin
      all_zero <= (count == CNT_W'(DATA_W));
      all_ones <= (count == '0);
    end
  end
`else
  assign all_zero = 1'b0;
  assign all_ones = 1'b0;
`endif

endmodule

// File: tb/tb_zero_count_task.sv
// Directed self-checking bench for zero_count_task (8-bit default plus a 16-bit instance).
module tb_zero_count_task;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [3:0]  out;
  logic        out_valid, all_zero, all_ones;

  logic        in_valid16 = 1'b0;
  logic [15:0] data16 = 16'h0000;
  logic [4:0]  out16;
  logic        out_valid16, all_zero16, all_ones16;

  int total = 0;
  int bad = 0;

`ifdef ZERO_COUNT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  always #5 clk = ~clk;

  zero_count_task #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(data),
    .out(out), .out_valid(out_valid), .all_zero(all_zero), .all_ones(all_ones)
  );

  zero_count_task #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .data(data16),
    .out(out16), .out_valid(out_valid16), .all_zero(all_zero16), .all_ones(all_ones16)
  );

  // Advance one active edge and settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; data = 8'h00;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (out !== 4'd0 || out_valid !== 1'b0 || all_zero !== 1'b0 || all_ones !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_cycle%0d: got out=%0d v=%b az=%b ao=%b want 0 0 0 0",
                 c, out, out_valid, all_zero, all_ones);
      end
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (out !== 4'd8 || out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL first_accept: got out=%0d v=%b want 8 1", out, out_valid);
    end
  endtask

  task automatic test_thermometer();
    logic [7:0] words [11] = '{8'hFF, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                               8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    logic [3:0] expect_cnt [11] = '{4'd0, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4,
                                    4'd3, 4'd2, 4'd1, 4'd0, 4'd8};
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      data = words[i];
      tick();
      total++;
      if (out !== expect_cnt[i] || out_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL thermo_%0d data=%h: got out=%0d v=%b want %0d 1",
                 i, words[i], out, out_valid, expect_cnt[i]);
      end
    end
  endtask

  task automatic test_idle_hold();
    in_valid = 1'b1; data = 8'h0F;
    tick();
    total++;
    if (out !== 4'd4 || out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_load: got out=%0d v=%b want 4 1", out, out_valid);
    end
    in_valid = 1'b0; data = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (out !== 4'd4 || out_valid !== 1'b0 || all_zero !== 1'b0 || all_ones !== 1'b0) begin
        bad++;
        $display("[TB] FAIL idle_hold%0d: got out=%0d v=%b az=%b ao=%b want 4 0 0 0",
                 c, out, out_valid, all_zero, all_ones);
      end
    end
  endtask

  task automatic test_flags();
    logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h5A};
    logic [3:0] expect_cnt [3] = '{4'd8, 4'd0, 4'd4};
    logic exp_az [3] = '{1'b1, 1'b0, 1'b0};
    logic exp_ao [3] = '{1'b0, 1'b1, 1'b0};
    logic az, ao;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = words[i];
      az = FLAGS & exp_az[i];
      ao = FLAGS & exp_ao[i];
      tick();
      total++;
      if (out !== expect_cnt[i] || all_zero !== az || all_ones !== ao) begin
        bad++;
        $display("[TB] FAIL flags_%h: got out=%0d az=%b ao=%b want %0d %b %b",
                 words[i], out, all_zero, all_ones, expect_cnt[i], az, ao);
      end
    end
    // With in_valid low the flags must hold the 8'h5A result even for an all-ones word.
    in_valid = 1'b0; data = 8'hFF;
    tick();
    total++;
    if (out !== 4'd4 || all_zero !== 1'b0 || all_ones !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flags_hold: got out=%0d v=%b az=%b ao=%b want 4 0 0 0",
               out, out_valid, all_zero, all_ones);
    end
  endtask

  task automatic test_midstream_reset();
    in_valid = 1'b1; data = 8'h01;
    tick();
    total++;
    if (out !== 4'd7 || out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_first: got out=%0d v=%b want 7 1", out, out_valid);
    end
    data = 8'h03; rst_n = 1'b0;
    tick();
    total++;
    if (out !== 4'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got out=%0d v=%b want 0 0", out, out_valid);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    total++;
    if (out !== 4'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_discard: got out=%0d v=%b want 0 0", out, out_valid);
    end
  endtask

  task automatic test_wide();
    in_valid16 = 1'b1; data16 = 16'h00F0;
    tick();
    total++;
    if (out16 !== 5'd12 || out_valid16 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wide_00F0: got out=%0d v=%b want 12 1", out16, out_valid16);
    end
    data16 = 16'h0000;
    tick();
    total++;
    if (out16 !== 5'd16 || all_zero16 !== FLAGS) begin
      bad++;
      $display("[TB] FAIL wide_0000: got out=%0d az=%b want 16 %b", out16, all_zero16, FLAGS);
    end
    data16 = 16'hFFFF;
    tick();
    total++;
    if (out16 !== 5'd0 || all_ones16 !== FLAGS) begin
      bad++;
      $display("[TB] FAIL wide_FFFF: got out=%0d ao=%b want 0 %b", out16, all_ones16, FLAGS);
    end
    in_valid16 = 1'b0;
    tick();
    total++;
    if (out16 !== 5'd0 || out_valid16 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wide_idle: got out=%0d v=%b want 0 0", out16, out_valid16);
    end
  endtask

  initial begin
    $display("[TB] starting zero_count_task bench, flags build=%b", FLAGS);
    test_reset();
    test_thermometer();
    test_idle_hold();
    test_flags();
    test_midstream_reset();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
